// File: rtl/coco_pic.sv
// coco_pic: fixed-priority interrupt controller with pending/mask/edge registers and an ack/EOI handshake to CP0.
// Optional macro PIC_SYNC2_EN turns the irq sample stage into a 2-flop synchronizer.

module coco_pic_lane (
    input  logic clk_i,
    input  logic rst_i,
    input  logic irq_i,
    input  logic edge_mode_i,
    input  logic w1c_i,
    input  logic eoi_clr_i,
    output logic pend_o
);
    logic irq_s_q;
    logic irq_d_q;
    logic pend_q, pend_d;
    logic rise;

`ifdef PIC_SYNC2_EN
    logic meta_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q  <= 1'b0;
            irq_s_q <= 1'b0;
        end else begin
            meta_q  <= irq_i;
            irq_s_q <= meta_q;
        end
    end
`else
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) irq_s_q <= 1'b0;
        else       irq_s_q <= irq_i;
    end
`endif

    assign rise = irq_s_q & ~irq_d_q;

    // Clears (W1C, EOI) are applied before the set term, so a coincident edge wins.
    always_comb begin
        pend_d = irq_s_q;
        if (edge_mode_i) pend_d = (pend_q & ~w1c_i & ~eoi_clr_i) | rise;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_d_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            irq_d_q <= irq_s_q;
            pend_q  <= pend_d;
        end
    end

    assign pend_o = pend_q;
endmodule

module coco_pic #(
    parameter int NUM_IRQ = 6,
    parameter int ID_W    = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [1:0]         add_i,
    input  logic               we_i,
    input  logic [31:0]        dat_i,
    output logic [31:0]        dat_o,
    input  logic [NUM_IRQ-1:0] irq_i,
    output logic               int_o,
    output logic [ID_W-1:0]    int_id_o,
    input  logic               ack_i,
    input  logic               eoi_i
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               int_q, int_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    svc_q, svc_d;
    logic [NUM_IRQ-1:0] mask_q, edge_mode_q;
    logic               gen_q;
    logic [NUM_IRQ-1:0] pend, w1c, eoi_clr;
    logic [ID_W-1:0]    cand_id;
    logic               cand_any, cand_valid;
    logic               unused_dat;

    assign unused_dat = ^dat_i[31:NUM_IRQ];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mask_q      <= '0;
            edge_mode_q <= '0;
            gen_q       <= 1'b0;
        end else if (we_i) begin
            case (add_i)
                2'd1:    mask_q      <= dat_i[NUM_IRQ-1:0];
                2'd2:    gen_q       <= dat_i[0];
                2'd3:    edge_mode_q <= dat_i[NUM_IRQ-1:0];
                default: ;
            endcase
        end
    end

    assign w1c = (we_i && add_i == 2'd0) ? dat_i[NUM_IRQ-1:0] : '0;

    // EOI retires the in-service edge line; level lines simply follow their input.
    always_comb begin
        eoi_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++)
            eoi_clr[i] = (state_q == ST_SVC) && eoi_i && edge_mode_q[i] && (svc_q == ID_W'(i));
    end

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_lane
        coco_pic_lane u_lane (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .irq_i       (irq_i[g]),
            .edge_mode_i (edge_mode_q[g]),
            .w1c_i       (w1c[g]),
            .eoi_clr_i   (eoi_clr[g]),
            .pend_o      (pend[g])
        );
    end

    // Scan high to low so the lowest enabled index is the one left standing.
    always_comb begin
        cand_any = 1'b0;
        cand_id  = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i] && mask_q[i]) begin
                cand_any = 1'b1;
                cand_id  = ID_W'(i);
            end
        end
    end

    assign cand_valid = cand_any & gen_q;

    always_comb begin
        state_d = state_q;
        int_d   = int_q;
        id_d    = id_q;
        svc_d   = svc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cand_valid) begin
                    state_d = ST_REQ;
                    int_d   = 1'b1;
                    id_d    = cand_id;
                end
            end
            ST_REQ: begin
                if (ack_i) begin
                    state_d = ST_SVC;
                    int_d   = 1'b0;
                    svc_d   = id_q;
                end else if (!cand_valid) begin
                    state_d = ST_IDLE;
                    int_d   = 1'b0;
                end else begin
                    id_d    = cand_id;
                end
            end
            ST_SVC: begin
                if (eoi_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            int_q   <= 1'b0;
            id_q    <= '0;
            svc_q   <= '0;
        end else begin
            state_q <= state_d;
            int_q   <= int_d;
            id_q    <= id_d;
            svc_q   <= svc_d;
        end
    end

    assign int_o    = int_q;
    assign int_id_o = id_q;

    always_comb begin
        dat_o = '0;
        case (add_i)
            2'd0: dat_o[NUM_IRQ-1:0] = pend;
            2'd1: dat_o[NUM_IRQ-1:0] = mask_q;
            2'd2: begin
                dat_o[0]        = gen_q;
                dat_o[2:1]      = state_q;
                dat_o[8 +: ID_W] = svc_q;
            end
            default: dat_o[NUM_IRQ-1:0] = edge_mode_q;
        endcase
    end
endmodule

// File: tb/tb_coco_pic.sv
// Scoreboard bench for coco_pic: driver updates a behavioural model each cycle and queues expectations, monitor compares.
module tb_coco_pic;
    localparam int N  = 6;
    localparam int IW = 4;
`ifdef PIC_SYNC2_EN
    localparam int SDEPTH = 2;
`else
    localparam int SDEPTH = 1;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [1:0]    add_i;
    logic          we_i;
    logic [31:0]   dat_i;
    logic [31:0]   dat_o;
    logic [N-1:0]  irq_i;
    logic          int_o;
    logic [IW-1:0] int_id_o;
    logic          ack_i;
    logic          eoi_i;

    always #5 clk_i = ~clk_i;

    coco_pic #(.NUM_IRQ(N), .ID_W(IW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .add_i(add_i), .we_i(we_i), .dat_i(dat_i),
        .dat_o(dat_o), .irq_i(irq_i), .int_o(int_o), .int_id_o(int_id_o),
        .ack_i(ack_i), .eoi_i(eoi_i)
    );

    typedef struct {
        logic [31:0]   dat;
        logic          intr;
        logic [IW-1:0] id;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 requesting, 2 in service.
    logic [N-1:0] m_pend, m_mask, m_edge, m_d;
    logic [N-1:0] m_samp [SDEPTH];
    logic         m_gen;
    int           m_phase, m_id, m_svc;
    bit           m_int;

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_edge = '0; m_d = '0; m_gen = 1'b0;
        for (int k = 0; k < SDEPTH; k++) m_samp[k] = '0;
        m_phase = 0; m_id = 0; m_svc = 0; m_int = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: r[N-1:0] = m_pend;
            2'd1: r[N-1:0] = m_mask;
            2'd2: begin r[0] = m_gen; r[2:1] = 2'(m_phase); r[8 +: IW] = IW'(m_svc); end
            default: r[N-1:0] = m_edge;
        endcase
        return r;
    endfunction

    task automatic model_step();
        logic [N-1:0] s, rise, w1c, clr;
        int  best;
        bit  any;
        s = m_samp[SDEPTH-1];
        rise = s & ~m_d;
        best = -1;
        for (int i = 0; i < N; i++)
            if (best < 0 && m_pend[i] && m_mask[i]) best = i;
        any = (best >= 0) && m_gen;
        w1c = (we_i && add_i == 2'd0) ? dat_i[N-1:0] : '0;
        clr = '0;
        if (m_phase == 2 && eoi_i && m_edge[m_svc]) clr[m_svc] = 1'b1;
        if (m_phase == 0) begin
            if (any) begin m_phase = 1; m_int = 1'b1; m_id = best; end
        end else if (m_phase == 1) begin
            if (ack_i) begin m_phase = 2; m_int = 1'b0; m_svc = m_id; end
            else if (!any) begin m_phase = 0; m_int = 1'b0; end
            else m_id = best;
        end else if (eoi_i) begin
            m_phase = 0;
        end
        m_pend = (~m_edge & s) | (m_edge & ((m_pend & ~w1c & ~clr) | rise));
        if (we_i) begin
            if (add_i == 2'd1) m_mask = dat_i[N-1:0];
            if (add_i == 2'd2) m_gen  = dat_i[0];
            if (add_i == 2'd3) m_edge = dat_i[N-1:0];
        end
        m_d = s;
        for (int k = SDEPTH - 1; k > 0; k--) m_samp[k] = m_samp[k-1];
        m_samp[0] = irq_i;
    endtask

    // One clock: queue what the DUT should show now, advance the model past the coming edge.
    task automatic tick();
        exp_t e;
        if (rst_i) model_reset();
        e.dat  = model_read(add_i);
        e.intr = m_int;
        e.id   = IW'(m_id);
        sb.push_back(e);
        if (!rst_i) model_step();
        @(negedge clk_i);
        rst_i = 1'b0; we_i = 1'b0; ack_i = 1'b0; eoi_i = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        add_i = 2'(a); dat_i = d; we_i = 1'b1;
        tick();
    endtask

    task automatic wait_int();
        for (int k = 0; k < 20 && !m_int; k++) tick();
    endtask

    task automatic pulse0();
        irq_i[0] = 1'b1; tick();
        irq_i[0] = 1'b0; repeat (4) tick();
    endtask

    task automatic drain();
        for (int k = 0; k < 12; k++) begin
            ack_i = m_int; eoi_i = (m_phase == 2);
            tick();
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("dat_o", dat_o, e.dat);
                chk("int_o", 32'(int_o), 32'(e.intr));
                chk("int_id_o", 32'(int_id_o), 32'(e.id));
            end
        end
    end

    initial begin : driver
        logic [N-1:0] one;
        one = 1;
        rst_i = 1'b1; add_i = '0; we_i = 1'b0; dat_i = '0; irq_i = '0; ack_i = 1'b0; eoi_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b1; tick();
        for (int a = 0; a < 4; a++) begin add_i = 2'(a); tick(); end

        // All lines high but masked: pending fills, no request.
        irq_i = '1; add_i = 2'd0;
        repeat (6) tick();
        irq_i = '0; repeat (3) tick();

        // Priority between lines 4 and 1, ack, then EOI with line 1 gone.
        wr(1, 32'h3F); wr(3, 32'h0); wr(2, 32'h1);
        irq_i = 6'b010010; add_i = 2'd2;
        wait_int();
        ack_i = 1'b1; tick();
        repeat (3) tick();
        irq_i = 6'b010000; repeat (4) tick();
        eoi_i = 1'b1; tick();
        wait_int();
        ack_i = 1'b1; tick();
        irq_i = '0; repeat (3) tick();
        eoi_i = 1'b1; tick();
        repeat (3) tick();

        // Edge line 0: held pending, cleared by EOI, re-armed by a pulse during service.
        wr(3, 32'h1); add_i = 2'd0;
        pulse0();
        wait_int();
        ack_i = 1'b1; tick();
        tick();
        eoi_i = 1'b1; tick();
        repeat (2) tick();
        pulse0();
        wait_int();
        ack_i = 1'b1; tick();
        pulse0();
        eoi_i = 1'b1; tick();
        wait_int();
        ack_i = 1'b1; tick();
        eoi_i = 1'b1; tick();
        repeat (2) tick();

        // W1C while requesting an edge line with nothing else pending.
        pulse0();
        wait_int();
        wr(0, 32'h1);
        repeat (3) tick();

        // W1C on line 2 coincident with its rising edge.
        wr(3, 32'h5);
        irq_i[2] = 1'b1;
        repeat (SDEPTH) tick();
        wr(0, 32'h4);
        add_i = 2'd0; repeat (3) tick();
        irq_i = '0;
        drain();

        // Asynchronous reset while in service.
        irq_i = 6'b001000; add_i = 2'd2;
        wait_int();
        ack_i = 1'b1; tick();
        tick();
        rst_i = 1'b1; tick();
        irq_i = '0; repeat (3) tick();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) irq_i = irq_i ^ (one << $urandom_range(0, N - 1));
            add_i = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 7) begin
                we_i = 1'b1; dat_i = $urandom;
                if (add_i == 2'd2) dat_i[0] = ($urandom_range(0, 3) != 0);
            end
            ack_i = m_int ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            eoi_i = (m_phase == 2) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0);
            if (c % 1000 == 999) rst_i = 1'b1;
            tick();
        end

        repeat (2) @(negedge clk_i);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/coco_pic.md
Name: coco_pic

Overview:
- Programmable interrupt controller that sits directly downstream of coco_timer and the other peripherals.
- Collects up to NUM_IRQ device irq lines, latches them as pending, applies a mask and a global enable, and picks one winner by fixed priority.
- Presents the winner to the CP0 stage as a single request with an id, and uses an ack/EOI handshake.
- Software accesses it through the same 2-bit word-address register port as the peripherals.

Parameters:
- NUM_IRQ, 6, number of interrupt inputs (1..16); line 0 has the highest priority.
- ID_W, 4, width of int_id_o; must satisfy 2**ID_W >= NUM_IRQ.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- add_i  in  2  register word address (bus bits [3:2]).
- we_i  in  1  register write strobe, one cycle.
- dat_i  in  32  write data.
- dat_o  out  32  read data, combinational on add_i.
- irq_i  in  NUM_IRQ  device interrupt lines (e.g. coco_timer irq).
- int_o  out  1  interrupt request to CP0, registered.
- int_id_o  out  ID_W  index of the request / in-service line, registered.
- ack_i  in  1  CP0 accepts the request, single-cycle pulse.
- eoi_i  in  1  end of interrupt from the handler, single-cycle pulse.

Behaviour:
- Register map:
  - 0 PEND: read pending[NUM_IRQ-1:0]; a write clears each pending bit where dat_i=1 (W1C).
  - 1 MASK: RW; 1 = line enabled.
  - 2 CTRL: bit0 GEN (global enable) is RW. Read-only fields: bits[2:1] state, bits[8+ID_W-1:8] in-service id.
  - 3 EDGE: RW; 1 = rising-edge triggered, 0 = level.
  - Unused read bits are 0.
- Reset values: all registers 0, state IDLE, int_o=0, int_id_o=0, sample flops 0.
- Sampling: irq_i passes through the sample stage to give irq_s; irq_d holds irq_s delayed one cycle.
- Pending update, per line, each cycle:
  - Level line: pending <= irq_s.
  - Edge line: pending set when irq_s & ~irq_d.
  - W1C on an edge line: clears the bit. A level line re-asserts on the next cycle while irq_s is high.
  - Set and clear in the same cycle: set wins.
- Candidate: lowest index i with pending[i] & MASK[i]; cand_valid = any such line & GEN.
- State machine:
  - IDLE:
    - if cand_valid -> REQ; int_o<=1, int_id_o<=candidate.
  - REQ:
    - ack_i -> SERVICE; int_o<=0; in-service id latched from int_id_o.
    - Candidate vanished without ack_i (masked, cleared, GEN=0) -> IDLE; int_o<=0.
    - Otherwise int_id_o tracks the current highest candidate every cycle.
  - SERVICE:
    - int_o held 0; new candidates are held pending but not requested.
    - eoi_i -> IDLE. If the in-service line is edge-mode, its pending bit is cleared in the same cycle; a new edge in that same cycle wins.
- ack_i outside REQ and eoi_i outside SERVICE are ignored.
- Latency:
  - irq_i rising before edge 1 gives irq_s=1 after edge 1, pending=1 after edge 2, int_o=1 after edge 3.
  - From the ack_i edge, int_o falls the same edge.
  - After EOI, a remaining candidate re-raises int_o 1 cycle later (SERVICE->IDLE->REQ).
- GEN=0 forces IDLE from REQ and blocks IDLE->REQ. SERVICE is unaffected, so EOI is still required.
- Register write and hardware event in the same cycle: the write is applied first, then the set-wins rule.
- Asynchronous reset mid-service returns everything to reset values immediately.

Optional Feature:
- Macro PIC_SYNC2_EN.
- Defined: the sample stage is a 2-flop synchronizer for asynchronous irq_i. All irq_i-to-output latencies grow by 1 cycle (int_o after edge 4).
- Undefined: single sample flop, with the latencies given above.

Test Plan:
- Reset, then read all 4 addresses -> 0. Hold irq_i=6'h3F with MASK=0 -> int_o stays 0, PEND reads 6'h3F.
- MASK=6'h3F, GEN=1, EDGE=0; raise irq_i[4] and irq_i[1] together -> int_o=1 three edges later with int_id_o=1. ack_i -> int_o=0, CTRL[9:8] reads 1, state SERVICE. eoi_i with irq_i[1] dropped -> int_id_o=4 and int_o=1 on the next request.
- EDGE[0]=1; pulse irq_i[0] for 1 cycle -> PEND[0]=1 held. ack_i then eoi_i -> PEND[0]=0. Second pulse during SERVICE -> PEND[0] stays 1 and is re-requested after EOI.
- In REQ, write PEND=6'h01 on an edge line 0 with no other candidates -> returns to IDLE and int_o=0 one edge later.
- Write PEND W1C on line 2 in the same cycle as an irq_i[2] rising edge -> PEND[2]=1 (set wins).
- Assert rst_i while in SERVICE -> int_o=0, int_id_o=0, all registers 0 without waiting for a clock. With PIC_SYNC2_EN defined, repeat scenario 2 -> int_o after 4 edges.
